// File: rtl/prime_readout.sv
// -----------------------------------------------------------------------------
// prime_readout
//
// Read-back side of the prime-entry path. One of the two stored primes is
// selected, converted to BCD by a sequential double-dabble engine (one input
// bit per clock), and shown in decimal on four active-low 7-segment digits.
// The selection moves on a debounced-by-edge push button press, or
// automatically every DWELL clocks when auto_en is high.
//
// Parameters
//   WIDTH        bit width of each stored prime (10 -> max 1023 -> 4 digits)
//   DWELL        clocks per entry when auto-alternating
//   SYNC_STAGES  flops in the next_n synchronizer (>= 2)
//
// Ports
//   clk           in   system clock
//   reset_n       in   asynchronous, active-low reset
//   prime0        in   stored first prime
//   prime1        in   stored second prime
//   prime0_valid  in   prime0 has been captured
//   prime1_valid  in   prime1 has been captured
//   next_n        in   raw push button, active-low, asynchronous
//   auto_en       in   1 = alternate entries every DWELL clocks
//   hex0..hex3    out  digits units..thousands, segments gfedcba, active-low
//   show_idx      out  index of the entry currently displayed
//   busy          out  conversion in progress
//   dbg_state     out  current FSM state (state_t encoding)
//
// Output contract: hex0..hex3 and show_idx are registered and change only on
// the clock edge that ends a conversion; that same edge drops busy. Every
// high-to-low transition of busy therefore marks exactly one fresh, complete
// display result, and the display is stable whenever busy is high.
// -----------------------------------------------------------------------------
module prime_readout #(
    parameter int WIDTH       = 10,
    parameter int DWELL       = 50_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] prime0,
    input  logic [WIDTH-1:0] prime1,
    input  logic             prime0_valid,
    input  logic             prime1_valid,
    input  logic             next_n,
    input  logic             auto_en,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic             show_idx,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    // -------------------------------------------------------------------------
    // Local constants
    // -------------------------------------------------------------------------
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [6:0]       SEG_BLANK  = 7'h7F;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CONV = 3'd2,
        ST_DONE = 3'd3,
        ST_SHOW = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Segment encoder (gfedcba, active-low)
    // -------------------------------------------------------------------------
    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // Button synchronizer and falling-edge detector
    // -------------------------------------------------------------------------
    // All flops reset high (button released) so reset release never looks
    // like a press. The edge detector yields one pulse per press no matter
    // how long the button is held.
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic                   w_next_pulse;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync      <= '1;
            r_sync_prev <= 1'b1;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], next_n};
            r_sync_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_next_pulse = r_sync_prev & ~r_sync[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Entry selection and dwell timer
    // -------------------------------------------------------------------------
    logic            r_idx;
    logic [DW_W-1:0] r_dwell;
    logic            w_cur_valid;
    logic            w_oth_valid;
    logic            w_dwell_hit;
    logic            w_force_move;
    logic            w_toggle;

    assign w_cur_valid  = r_idx ? prime1_valid : prime0_valid;
    assign w_oth_valid  = r_idx ? prime0_valid : prime1_valid;
    assign w_dwell_hit  = auto_en && (r_dwell == DWELL_LAST);
    // Never sit on an invalid entry while the other one holds a value.
    assign w_force_move = !w_cur_valid && w_oth_valid;
    assign w_toggle     = w_force_move ||
                          ((w_next_pulse || w_dwell_hit) && w_oth_valid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx   <= 1'b0;
            r_dwell <= '0;
        end else begin
            r_idx <= r_idx ^ w_toggle;
            // Restart the dwell period on any manual or automatic change so a
            // press always buys a full DWELL on the newly chosen entry.
            if (!auto_en || w_toggle || w_next_pulse || w_dwell_hit) begin
                r_dwell <= '0;
            end else begin
                r_dwell <= r_dwell + DW_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Trigger: selected entry differs from what the last conversion captured
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] w_sel_val;
    logic             w_sel_valid;
    logic [WIDTH-1:0] r_snap_val;
    logic             r_snap_valid;
    logic             r_snap_idx;
    logic             w_trig;

    assign w_sel_val   = r_idx ? prime1 : prime0;
    assign w_sel_valid = w_cur_valid;
    assign w_trig      = (w_sel_val != r_snap_val) ||
                         (w_sel_valid != r_snap_valid) ||
                         (r_idx != r_snap_idx);

    // -------------------------------------------------------------------------
    // Double-dabble datapath
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] r_shift;
    logic [15:0]      r_bcd;
    logic [CNT_W-1:0] r_bitcnt;
    logic [14:0]      w_bcd_adj;
    logic [15:0]      w_bcd_next;

    // Add 3 to every nibble >= 5 before the shift. The top nibble only needs
    // its low three bits kept, since its MSB is shifted out.
    always_comb begin
        w_bcd_adj = '0;
        for (int i = 0; i < 3; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end else begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4];
            end
        end
        if (r_bcd[15:12] >= 4'd5) begin
            w_bcd_adj[14:12] = r_bcd[14:12] + 3'd3;
        end else begin
            w_bcd_adj[14:12] = r_bcd[14:12];
        end
    end

    assign w_bcd_next = {w_bcd_adj, r_shift[WIDTH-1]};

    // -------------------------------------------------------------------------
    // Display image of the final conversion step, with leading-zero blanking
    // -------------------------------------------------------------------------
    logic [3:0] w_d0, w_d1, w_d2, w_d3;
    logic       w_lz3, w_lz2, w_lz1;
    logic [6:0] w_hex0, w_hex1, w_hex2, w_hex3;

    assign w_d0 = w_bcd_next[3:0];
    assign w_d1 = w_bcd_next[7:4];
    assign w_d2 = w_bcd_next[11:8];
    assign w_d3 = w_bcd_next[15:12];

    // A digit is a leading zero when it and every higher digit are zero.
    assign w_lz3 = (w_d3 == 4'd0);
    assign w_lz2 = w_lz3 && (w_d2 == 4'd0);
    assign w_lz1 = w_lz2 && (w_d1 == 4'd0);

    always_comb begin
        w_hex0 = SEG_BLANK;
        w_hex1 = SEG_BLANK;
        w_hex2 = SEG_BLANK;
        w_hex3 = SEG_BLANK;
        if (r_snap_valid) begin
            w_hex0 = f_seg(w_d0);
            if (!w_lz1) w_hex1 = f_seg(w_d1);
            if (!w_lz2) w_hex2 = f_seg(w_d2);
            if (!w_lz3) w_hex3 = f_seg(w_d3);
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    // The result is written to the display on the last CONV edge, so the
    // DONE cycle already shows it with busy low. A change seen during a
    // conversion is remembered in r_pending and serviced after DONE rather
    // than aborting the conversion in flight.
    state_t     r_state;
    logic       r_pending;
    logic       r_busy;
    logic       r_show_idx;
    logic [6:0] r_hex0, r_hex1, r_hex2, r_hex3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_pending    <= 1'b0;
            r_busy       <= 1'b0;
            r_show_idx   <= 1'b0;
            r_snap_val   <= '0;
            r_snap_valid <= 1'b0;
            r_snap_idx   <= 1'b0;
            r_shift      <= '0;
            r_bcd        <= '0;
            r_bitcnt     <= '0;
            r_hex0       <= SEG_BLANK;
            r_hex1       <= SEG_BLANK;
            r_hex2       <= SEG_BLANK;
            r_hex3       <= SEG_BLANK;
        end else begin
            case (r_state)
                ST_IDLE, ST_SHOW: begin
                    if (w_trig) begin
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    r_snap_val   <= w_sel_val;
                    r_snap_valid <= w_sel_valid;
                    r_snap_idx   <= r_idx;
                    r_shift      <= w_sel_val;
                    r_bcd        <= '0;
                    r_bitcnt     <= '0;
                    r_pending    <= 1'b0;
                    r_state      <= ST_CONV;
                end

                ST_CONV: begin
                    r_shift  <= {r_shift[WIDTH-2:0], 1'b0};
                    r_bcd    <= w_bcd_next;
                    r_bitcnt <= r_bitcnt + CNT_W'(1);
                    if (w_trig) begin
                        r_pending <= 1'b1;
                    end
                    if (r_bitcnt == CNT_LAST) begin
                        r_hex0     <= w_hex0;
                        r_hex1     <= w_hex1;
                        r_hex2     <= w_hex2;
                        r_hex3     <= w_hex3;
                        r_show_idx <= r_snap_idx;
                        r_busy     <= 1'b0;
                        r_state    <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_pending <= 1'b0;
                    if (r_pending || w_trig) begin
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_SHOW;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign hex0      = r_hex0;
    assign hex1      = r_hex1;
    assign hex2      = r_hex2;
    assign hex3      = r_hex3;
    assign show_idx  = r_show_idx;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_prime_readout.sv
// -----------------------------------------------------------------------------
// tb_prime_readout
//
// Self-checking bench for prime_readout. The stimulus side applies one change
// at a time and, using a decimal reference model of the selection and display
// rules, pushes the display it expects into exp_q. A monitor pops exp_q each
// time busy falls and compares {show_idx, hex3..hex0}; any display change at
// another moment, or a display nobody expected, is reported.
// DWELL is shortened so that a whole conversion fits inside one dwell period.
// -----------------------------------------------------------------------------
module tb_prime_readout;

    localparam int WIDTH    = 10;
    localparam int DWELL_TB = 20;
    localparam int SYNC_TB  = 2;

    // -------------------------------------------------------------------------
    // Clock / reset / DUT
    // -------------------------------------------------------------------------
    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] prime0, prime1;
    logic             prime0_valid, prime1_valid;
    logic             next_n, auto_en;
    logic [6:0]       hex0, hex1, hex2, hex3;
    logic             show_idx, busy;
    logic [2:0]       dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    prime_readout #(
        .WIDTH      (WIDTH),
        .DWELL      (DWELL_TB),
        .SYNC_STAGES(SYNC_TB)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .prime0      (prime0),
        .prime1      (prime1),
        .prime0_valid(prime0_valid),
        .prime1_valid(prime1_valid),
        .next_n      (next_n),
        .auto_en     (auto_en),
        .hex0        (hex0),
        .hex1        (hex1),
        .hex2        (hex2),
        .hex3        (hex3),
        .show_idx    (show_idx),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};
    int corner_tab [0:8] = '{0, 1, 9, 10, 99, 100, 999, 1000, 1023};

    logic [28:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    bit m_idx;        // entry the model says is selected
    int disp_val;     // entry captured by the most recent conversion
    bit disp_valid;
    bit disp_idx;

    // Decimal digits by division; blank higher digits below 10/100/1000.
    function automatic logic [27:0] ref_hex(input int value, input bit valid);
        logic [6:0] h3, h2, h1, h0;
        if (!valid) return {4{7'h7F}};
        h0 = seg_tab[value % 10];
        h1 = (value >= 10)   ? seg_tab[(value / 10) % 10]  : 7'h7F;
        h2 = (value >= 100)  ? seg_tab[(value / 100) % 10] : 7'h7F;
        h3 = (value >= 1000) ? seg_tab[(value / 1000) % 10] : 7'h7F;
        return {h3, h2, h1, h0};
    endfunction

    task automatic model_reset();
        m_idx      = 1'b0;
        disp_val   = 0;
        disp_valid = 1'b0;
        disp_idx   = 1'b0;
    endtask

    // Apply the "move off an invalid entry" rule, then expect one display
    // whenever the selected entry differs from the one last converted.
    task automatic model_update();
        bit cur_v, oth_v;
        int val;
        cur_v = m_idx ? prime1_valid : prime0_valid;
        oth_v = m_idx ? prime0_valid : prime1_valid;
        if (!cur_v && oth_v) m_idx = ~m_idx;
        val   = m_idx ? int'(prime1) : int'(prime0);
        cur_v = m_idx ? prime1_valid : prime0_valid;
        if (val != disp_val || cur_v != disp_valid || m_idx != disp_idx) begin
            exp_q.push_back({m_idx, ref_hex(val, cur_v)});
            disp_val   = val;
            disp_valid = cur_v;
            disp_idx   = m_idx;
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor / scoreboard
    // -------------------------------------------------------------------------
    logic        prev_busy = 1'b0;
    logic [27:0] prev_hex  = {4{7'h7F}};
    logic [27:0] cur_hex;
    logic [28:0] mon_exp;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_busy = 1'b0;
            prev_hex  = {4{7'h7F}};
        end else begin
            cur_hex = {hex3, hex2, hex1, hex0};
            if (prev_busy && !busy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_display: got idx=%0d hex=%07h, required no display",
                             show_idx, cur_hex);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({show_idx, cur_hex} !== mon_exp) begin
                        errors++;
                        $display("FAIL display: got idx=%0d hex=%07h, required idx=%0d hex=%07h",
                                 show_idx, cur_hex, mon_exp[28], mon_exp[27:0]);
                    end
                end
            end else if (cur_hex !== prev_hex) begin
                checks++;
                errors++;
                $display("FAIL hex_stable: hex changed %07h -> %07h outside a completed conversion",
                         prev_hex, cur_hex);
            end
            prev_busy = busy;
            prev_hex  = cur_hex;
        end
    end

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d displays outstanding after %0d cycles, required 0",
                     exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic settle();
        wait_idle(80);
        repeat (30) @(posedge clk);
        #1;
    endtask

    task automatic press(input int hold);
        bit oth_v;
        next_n = 1'b0;
        oth_v  = m_idx ? prime0_valid : prime1_valid;
        if (oth_v) m_idx = ~m_idx;
        model_update();
        repeat (hold) @(posedge clk);
        #1;
        next_n = 1'b1;
        settle();
    endtask

    function automatic int rand_value();
        if ($urandom_range(0, 1) == 1) return corner_tab[$urandom_range(0, 8)];
        return int'($urandom_range(0, 1023));
    endfunction

    // -------------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        int lat;
        int t_prev;
        int t_now;
        int n;
        bit last_idx;
        int v;

        reset_n      = 1'b0;
        prime0       = '0;
        prime1       = '0;
        prime0_valid = 1'b0;
        prime1_valid = 1'b0;
        next_n       = 1'b1;
        auto_en      = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("reset_hex", {hex3, hex2, hex1, hex0}, {4{7'h7F}});
        check("reset_busy", busy, 0);
        check("reset_show_idx", show_idx, 0);
        check("reset_state", dbg_state, 0);
        reset_n = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // 13 on entry 0, with trigger-to-display latency
        prime0       = 10'd13;
        prime0_valid = 1'b1;
        model_update();
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (hex0 !== 7'h7F) lat = k;
        end
        check("latency_clks", lat, WIDTH + 2);
        check("t1_hex", {hex3, hex2, hex1, hex0}, {7'h7F, 7'h7F, 7'b1111001, 7'b0110000});
        check("t1_show_idx", show_idx, 0);
        settle();

        // 1021 on entry 1; a long press toggles exactly once
        prime1       = 10'd1021;
        prime1_valid = 1'b1;
        model_update();
        settle();
        press(20);
        check("t2_hex", {hex3, hex2, hex1, hex0},
              {7'b1111001, 7'b1000000, 7'b0100100, 7'b1111001});
        check("t2_show_idx", show_idx, 1);

        // Value change during a conversion: old value first, then the new one
        press(4);
        prime0 = 10'd7;
        model_update();
        repeat (5) @(posedge clk);
        #1;
        prime0 = 10'd11;
        model_update();
        settle();
        check("t5_hex", {hex3, hex2, hex1, hex0}, {7'h7F, 7'h7F, 7'b1111001, 7'b1111001});

        // No valid entry: blank display, press does not move the selection
        prime0_valid = 1'b0;
        prime1_valid = 1'b0;
        model_update();
        settle();
        press(3);
        check("t3_hex", {hex3, hex2, hex1, hex0}, {4{7'h7F}});
        check("t3_busy", busy, 0);
        check("t3_show_idx", show_idx, 0);

        // Reset in the middle of a conversion
        prime0       = 10'd500;
        prime0_valid = 1'b1;
        model_update();
        repeat (7) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_reset_hex", {hex3, hex2, hex1, hex0}, {4{7'h7F}});
        check("t6_reset_busy", busy, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        model_update();
        settle();
        check("t6_recover_hex", {hex3, hex2, hex1, hex0},
              {7'h7F, 7'b0010010, 7'b1000000, 7'b1000000});

        // Auto-alternate 7 / 997
        prime0       = 10'd7;
        prime1       = 10'd997;
        prime1_valid = 1'b1;
        model_update();
        settle();
        auto_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            m_idx = ~m_idx;
            model_update();
        end
        last_idx = show_idx;
        t_prev   = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (show_idx === last_idx && n < 80) begin
                @(posedge clk);
                #1;
                n++;
            end
            t_now    = cyc;
            last_idx = show_idx;
            if (k > 0) check("auto_period", t_now - t_prev, DWELL_TB);
            t_prev = t_now;
        end
        auto_en = 1'b0;
        settle();

        // Randomized single-step changes
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    v            = rand_value();
                    prime0       = 10'(v);
                    prime0_valid = 1'($urandom_range(0, 3) != 0);
                    model_update();
                    settle();
                end
                1: begin
                    v            = rand_value();
                    prime1       = 10'(v);
                    prime1_valid = 1'($urandom_range(0, 3) != 0);
                    model_update();
                    settle();
                end
                2: begin
                    press(int'($urandom_range(1, 20)));
                end
                default: begin
                    if ($urandom_range(0, 1) == 1) prime0_valid = ~prime0_valid;
                    else                           prime1_valid = ~prime1_valid;
                    model_update();
                    settle();
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
